uc_multiciclo: RTL and testbench

UC_MULTICICLO -- requirements
Module: uc_multiciclo

---
 rtl/uc_pkg.sv | 59 +++++
 rtl/uc_opdecode.sv | 38 +++
 rtl/uc_multiciclo.sv | 174 +++++++++++++++++
 tb/tb_uc_multiciclo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types for the multi-cycle control unit: state encoding, opcode classes,
// opcode constants, ALU commands and the control-word bundle.
package uc_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        EXEC_LI  = 4'd5,
        ALU_WB   = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_ILL
    } opclass_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_I   = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b100010;
    localparam logic [5:0] OP_SW  = 6'b101010;
    localparam logic [5:0] OP_LI  = 6'b100011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000110;
    localparam logic [5:0] OP_J   = 6'b010000;

    localparam logic [2:0] ALU_FUNCT  = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_LUI    = 3'b011;
    localparam logic [2:0] ALU_SUB_EQ = 3'b100;
    localparam logic [2:0] ALU_SUB_NE = 3'b101;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       branch_ne;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/uc_opdecode.sv
// Combinational opcode classifier; any set bit above the low six marks the opcode illegal.
module uc_opdecode
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output opclass_t            cls
);

    logic upper_nz;

    generate
        if (OPCODE_W > 6) begin : g_upper
            assign upper_nz = |opcode[OPCODE_W-1:6];
        end else begin : g_noupper
            assign upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        cls = CLS_ILL;
        if (!upper_nz) begin
            case (opcode[5:0])
                OP_R:    cls = CLS_R;
                OP_I:    cls = CLS_I;
                OP_LI:   cls = CLS_LI;
                OP_LW:   cls = CLS_LW;
                OP_SW:   cls = CLS_SW;
                OP_BEQ:  cls = CLS_BEQ;
                OP_BNE:  cls = CLS_BNE;
                OP_J:    cls = CLS_J;
                default: cls = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle datapath control FSM. Define UC_ILLEGAL_TRAP_EN to lock up in TRAP on an
// illegal opcode; otherwise an illegal opcode retires in DECODE and fetch resumes.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                branch_ne,
    output logic                instr_done,
    output logic [STATE_W-1:0]  state_dbg
);

`ifdef UC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t   state, state_nx;
    opclass_t cls_dec, cls_q;
    ctrl_t    c;

    uc_opdecode #(.OPCODE_W(OPCODE_W)) u_opdecode (
        .opcode (opcode),
        .cls    (cls_dec)
    );

    // The class is captured in DECODE so later opcode changes cannot redirect the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cls_q <= CLS_ILL;
        end else begin
            state <= state_nx;
            if (state == DECODE) cls_q <= cls_dec;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = FETCH;
            FETCH:    if (mem_ready) state_nx = DECODE;
            DECODE: begin
                case (cls_dec)
                    CLS_R:           state_nx = EXEC_R;
                    CLS_I:           state_nx = EXEC_I;
                    CLS_LI:          state_nx = EXEC_LI;
                    CLS_LW, CLS_SW:  state_nx = MEM_ADDR;
                    CLS_BEQ, CLS_BNE: state_nx = BRANCH;
                    CLS_J:           state_nx = JUMP;
                    default:         state_nx = TRAP_EN ? TRAP : FETCH;
                endcase
            end
            EXEC_R, EXEC_I, EXEC_LI: state_nx = ALU_WB;
            ALU_WB:   state_nx = FETCH;
            MEM_ADDR: state_nx = (cls_q == CLS_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) state_nx = MEM_WB;
            MEM_WB:   state_nx = FETCH;
            MEM_WR:   if (mem_ready) state_nx = FETCH;
            BRANCH, JUMP: state_nx = FETCH;
            TRAP:     state_nx = TRAP;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            DECODE: begin
                c.alu_src_b  = 2'b11;
                c.alu_op     = ALU_ADD;
                c.instr_done = !TRAP_EN && (cls_dec == CLS_ILL);
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
                c.reg_dst   = 1'b1;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_FUNCT;
                c.reg_dst   = 1'b1;
            end
            EXEC_LI: begin
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_LUI;
            end
            ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = (cls_q == CLS_R) || (cls_q == CLS_I);
                c.instr_done = 1'b1;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            MEM_WR: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = mem_ready;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
                c.branch_ne     = (cls_q == CLS_BNE);
                c.alu_op        = (cls_q == CLS_BNE) ? ALU_SUB_NE : ALU_SUB_EQ;
            end
            JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign pc_write      = c.pc_write;
    assign pc_write_cond = c.pc_write_cond;
    assign ir_write      = c.ir_write;
    assign i_or_d        = c.i_or_d;
    assign mem_read      = c.mem_read;
    assign mem_write     = c.mem_write;
    assign mem_to_reg    = c.mem_to_reg;
    assign reg_dst       = c.reg_dst;
    assign reg_write     = c.reg_write;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign pc_source     = c.pc_source;
    assign alu_op        = ALUOP_W'(c.alu_op);
    assign branch_ne     = c.branch_ne;
    assign instr_done    = c.instr_done;
    assign state_dbg     = STATE_W'(state);

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: fixed vector table, hand sequences for reset/illegal opcodes,
// and random instructions checked against per-instruction aggregate expectations.
module tb_uc_multiciclo;
    import uc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, branch_ne, instr_done;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_dbg;
    logic [18:0] ctl;

    int total = 0;
    int bad   = 0;

    uc_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .branch_ne(branch_ne), .instr_done(instr_done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {pw,pwc,irw,iod}_{mrd,mwr,m2r,rdst}_{rw,asa}_asb_psrc_aluop_{bne,done}
    assign ctl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, branch_ne, instr_done};

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        state_t      st;
        logic [18:0] ctl;
    } vec_t;

    vec_t tbl[14];

`ifdef UC_ILLEGAL_TRAP_EN
    localparam int NOPS = 8;
`else
    localparam int NOPS = 10;
`endif
    logic [5:0] ops[10] = '{6'b000000, 6'b000001, 6'b100011, 6'b100010, 6'b101010,
                            6'b000100, 6'b000110, 6'b010000, 6'b111111, 6'b110000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one tick after an edge with reset released and the FSM in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        opcode = '0;
        mem_ready = 1'b0;
        #1;
        chk("rst_ctl", ctl, 0);
        chk("rst_state", state_dbg, IDLE);
        step();
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH; st0/st1 are stall cycles in the fetch and data access.
    task automatic run_instr(input logic [5:0] op, input int st0, input int st1);
        int base = 2, e_rw = 0, e_m2r = 0, e_mw = 0, e_mr, e_pw = 1, e_pwc = 0, e_bne = 0;
        int e_rd = 0, e_aop = 0;
        int n_rw = 0, n_m2r = 0, n_mw = 0, n_mr = 0, n_pw = 0, n_pwc = 0, n_bne = 0;
        int done_cnt = 0, done_idx = -1, rd_seen = 0, aop_seen = 0;
        bit is_mem = 0;
        logic mrq[$];
        case (op)
            6'b000000, 6'b000001: begin base = 4; e_rw = 1; e_rd = 1; end
            6'b100011: begin base = 4; e_rw = 1; end
            6'b100010: begin base = 5; e_rw = 1; e_m2r = 1; is_mem = 1; end
            6'b101010: begin base = 4; e_mw = st1 + 1; is_mem = 1; end
            6'b000100: begin base = 3; e_pwc = 1; e_aop = 4; end
            6'b000110: begin base = 3; e_pwc = 1; e_bne = 1; e_aop = 5; end
            6'b010000: begin base = 3; e_pw = 2; end
            default:   base = 2;
        endcase
        e_mr = st0 + 1 + ((op == 6'b100010) ? st1 + 1 : 0);
        for (int p = 0; p < base; p++) begin
            if (p == 0) begin
                repeat (st0) mrq.push_back(1'b0);
                mrq.push_back(1'b1);
            end else if (p == 3 && is_mem) begin
                repeat (st1) mrq.push_back(1'b0);
                mrq.push_back(1'b1);
            end else begin
                mrq.push_back(1'($urandom_range(0, 1)));
            end
        end
        chk("start_fetch", state_dbg, FETCH);
        for (int i = 0; i < mrq.size(); i++) begin
            opcode = (i <= st0 + 1) ? op : 6'($urandom_range(0, 63));
            mem_ready = mrq[i];
            #1;
            if (reg_write) begin n_rw++; rd_seen = int'(reg_dst); end
            if (mem_to_reg) n_m2r++;
            if (mem_write) n_mw++;
            if (mem_read) n_mr++;
            if (pc_write) n_pw++;
            if (pc_write_cond) begin n_pwc++; aop_seen = int'(alu_op); end
            if (branch_ne) n_bne++;
            if (instr_done) begin done_cnt++; done_idx = i; end
            step();
        end
        chk("latency", done_idx + 1, base + st0 + (is_mem ? st1 : 0));
        chk("done_cnt", done_cnt, 1);
        chk("reg_write_cnt", n_rw, e_rw);
        chk("mem_to_reg_cnt", n_m2r, e_m2r);
        chk("mem_write_cnt", n_mw, e_mw);
        chk("mem_read_cnt", n_mr, e_mr);
        chk("pc_write_cnt", n_pw, e_pw);
        chk("pc_write_cond_cnt", n_pwc, e_pwc);
        chk("branch_ne_cnt", n_bne, e_bne);
        if (e_rw != 0) chk("reg_dst_wb", rd_seen, e_rd);
        if (e_pwc != 0) chk("branch_alu_op", aop_seen, e_aop);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{6'b000000, 1'b1, IDLE,     19'b0000_0000_00_00_00_000_00};
        tbl[1]  = '{6'b000000, 1'b1, FETCH,    19'b1010_1000_00_01_00_001_00};
        tbl[2]  = '{6'b000000, 1'b1, DECODE,   19'b0000_0000_00_11_00_001_00};
        tbl[3]  = '{6'b000000, 1'b1, EXEC_R,   19'b0000_0001_01_00_00_000_00};
        tbl[4]  = '{6'b000000, 1'b1, ALU_WB,   19'b0000_0001_10_00_00_000_01};
        tbl[5]  = '{6'b000110, 1'b0, FETCH,    19'b0000_1000_00_01_00_001_00};
        tbl[6]  = '{6'b000110, 1'b1, FETCH,    19'b1010_1000_00_01_00_001_00};
        tbl[7]  = '{6'b000110, 1'b1, DECODE,   19'b0000_0000_00_11_00_001_00};
        tbl[8]  = '{6'b000110, 1'b1, BRANCH,   19'b0100_0000_01_00_01_101_11};
        tbl[9]  = '{6'b101010, 1'b1, FETCH,    19'b1010_1000_00_01_00_001_00};
        tbl[10] = '{6'b101010, 1'b1, DECODE,   19'b0000_0000_00_11_00_001_00};
        tbl[11] = '{6'b100010, 1'b1, MEM_ADDR, 19'b0000_0000_01_10_00_001_00};
        tbl[12] = '{6'b000000, 1'b0, MEM_WR,   19'b0001_0100_00_00_00_000_00};
        tbl[13] = '{6'b000100, 1'b1, MEM_WR,   19'b0001_0100_00_00_00_000_01};

        rst_n = 1'b0;
        opcode = '0;
        mem_ready = 1'b0;
        step();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            opcode = tbl[i].op;
            mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("tbl%0d_state", i), state_dbg, tbl[i].st);
            chk($sformatf("tbl%0d_ctl", i), ctl, tbl[i].ctl);
            step();
        end

        // Load with a two-cycle data stall: seven cycles in total.
        run_instr(6'b100010, 0, 2);

        // Illegal opcode handling.
        chk("ill_start", state_dbg, FETCH);
        opcode = 6'b111111;
        mem_ready = 1'b1;
        #1;
        step();
        chk("ill_decode_state", state_dbg, DECODE);
`ifdef UC_ILLEGAL_TRAP_EN
        chk("ill_decode_done", instr_done, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            opcode = 6'($urandom_range(0, 63));
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("trap_state", state_dbg, TRAP);
            chk("trap_ctl", ctl, 0);
            step();
        end
        do_reset();
        #1;
        chk("post_trap_idle", state_dbg, IDLE);
        step();
`else
        chk("ill_decode_done", instr_done, 1'b1);
        step();
`endif

        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, NOPS - 1)], $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a stalled store.
        chk("ar_start", state_dbg, FETCH);
        opcode = 6'b101010;
        mem_ready = 1'b1;
        step();
        step();
        step();
        mem_ready = 1'b0;
        #1;
        chk("ar_in_memwr", state_dbg, MEM_WR);
        chk("ar_mem_write_before", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mem_write_after", mem_write, 1'b0);
        chk("ar_ctl_zero", ctl, 0);
        chk("ar_state_idle", state_dbg, IDLE);
        step();
        chk("ar_held_idle", state_dbg, IDLE);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("ar_release_idle", state_dbg, IDLE);
        step();
        chk("ar_then_fetch", state_dbg, FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
